// File: rtl/mdu_hilo_pkg.sv
// Shared definitions for the MDU: md_op opcodes, FSM state type, op decode helpers.
// Latency: none (package only).
// Backpressure: none (package only).
package mdu_hilo_pkg;

  // md_op encoding emitted by the decode controller; 9..15 decode as no-op.
  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_t;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_hilo_md_calc.sv
// Combinational MDU arithmetic: 64-bit product, quotient, remainder and divide-by-zero flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow inputs continuously.
//
// Ports: i_op (md_op, selects signed/unsigned), i_a/i_b (rs/rt operands),
//        o_prod (64-bit product), o_quot/o_rem (quotient/remainder), o_div_zero (i_b==0).
module mdu_hilo_md_calc
  import mdu_hilo_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_prod,
  output logic [31:0] o_quot,
  output logic [31:0] o_rem,
  output logic        o_div_zero
);

  logic        w_signed;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_den;
  logic [31:0] w_uquot;
  logic [31:0] w_urem;

  always_comb begin
    w_signed = (i_op == MD_MULT) || (i_op == MD_DIV);

    // Sign- or zero-extend to 64 bits; the low 64 bits of a 64x64 product
    // are then the correct signed or unsigned 32x32 product.
    w_a_ext = {{32{w_signed & i_a[31]}}, i_a};
    w_b_ext = {{32{w_signed & i_b[31]}}, i_b};
    o_prod  = w_a_ext * w_b_ext;

    // Divide on magnitudes, then restore signs: quotient truncates toward
    // zero, remainder follows the dividend. -2^31 / -1 wraps to 0x80000000.
    w_a_neg = w_signed & i_a[31];
    w_b_neg = w_signed & i_b[31];
    w_a_mag = w_a_neg ? (32'd0 - i_a) : i_a;
    w_b_mag = w_b_neg ? (32'd0 - i_b) : i_b;

    // Keep the divider away from a zero denominator; the result is discarded.
    o_div_zero = (i_b == 32'd0);
    w_den      = o_div_zero ? 32'd1 : w_b_mag;
    w_uquot    = w_a_mag / w_den;
    w_urem     = w_a_mag % w_den;

    o_quot = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uquot) : w_uquot;
    o_rem  = w_a_neg ? (32'd0 - w_urem) : w_urem;
  end

endmodule

// File: rtl/mdu_hilo.sv
// E-stage multiply/divide unit with HI/LO registers and fixed multi-cycle latency.
// Latency: mult/multu commit MULT_CYCLES edges after start, div/divu DIV_CYCLES; mthi/mtlo same edge.
// Backpressure: busy high while an op is in flight; start/mthi/mtlo are dropped while busy or under req.
//
// Ports: clk, reset (async active-low), start (mult/div in E), md_op (opcode),
//        A/B (rs/rt), req (exception taken), busy, HI, LO, md_out (HI on MFHI else LO).
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_out
);

  localparam logic [3:0] LP_MUL_N = 4'(MULT_CYCLES);
  localparam logic [3:0] LP_DIV_N = 4'(DIV_CYCLES);

  md_state_t   r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_hi_t;
  logic [31:0] r_lo_t;
  logic        r_dz;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [63:0] w_prod;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic        w_div_zero;
  logic        w_go;

  mdu_hilo_md_calc u_md_calc (
    .i_op       (md_op),
    .i_a        (A),
    .i_b        (B),
    .o_prod     (w_prod),
    .o_quot     (w_quot),
    .o_rem      (w_rem),
    .o_div_zero (w_div_zero)
  );

  assign w_go = start && !req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_hi_t  <= 32'd0;
      r_lo_t  <= 32'd0;
      r_dz    <= 1'b0;
      r_busy  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_go && is_mul_op(md_op)) begin
            {r_hi_t, r_lo_t} <= w_prod;
            r_dz    <= 1'b0;
            r_cnt   <= LP_MUL_N;
            r_busy  <= 1'b1;
            r_state <= ST_MUL;
          end else if (w_go && is_div_op(md_op)) begin
            r_hi_t  <= w_rem;
            r_lo_t  <= w_quot;
            r_dz    <= w_div_zero;
            r_cnt   <= LP_DIV_N;
            r_busy  <= 1'b1;
            r_state <= ST_DIV;
          end else if (!start && !req) begin
            // Move-to writes only when no arithmetic start is present.
            if (md_op == MD_MTHI) r_hi <= A;
            if (md_op == MD_MTLO) r_lo <= A;
          end
        end
        default: begin
          // In flight: all new requests ignored; req does not abort.
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            if (!r_dz) begin
              r_hi <= r_hi_t;
              r_lo <= r_lo_t;
            end
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign HI     = r_hi;
  assign LO     = r_lo;
  assign md_out = (md_op == MD_MFHI) ? r_hi : r_lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed scenarios plus randomized ops against a
// longint reference model; commits are checked by a monitor popping a scoreboard queue.
module tb_mdu_hilo;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam int N_MUL = 5;
  localparam int N_DIV = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        req;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] md_out;

  always #5 clk = ~clk;

  mdu_hilo #(.MULT_CYCLES(N_MUL), .DIV_CYCLES(N_DIV)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .A      (A),
    .B      (B),
    .req    (req),
    .busy   (busy),
    .HI     (HI),
    .LO     (LO),
    .md_out (md_out)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural reference: MIPS mult/div semantics in 64-bit integer arithmetic.
  task automatic ref_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sp, sa, sb, q, r;
    logic [63:0] up;
    case (op)
      OP_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        m_hi = sp[63:32];
        m_lo = sp[31:0];
      end
      OP_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        m_hi = up[63:32];
        m_lo = up[31:0];
      end
      OP_DIV: if (b != 32'd0) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = sa / sb;
        r = sa % sb;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      OP_DIVU: if (b != 32'd0) begin
        m_lo = a / b;
        m_hi = a % b;
      end
      default: ;
    endcase
  endtask

  // Called right after a negedge; inputs are sampled at the following posedge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic rq);
    exp_t e;
    start = 1'b1;
    md_op = op;
    A     = a;
    B     = b;
    req   = rq;
    if (!rq && op >= OP_MULT && op <= OP_DIVU) begin
      ref_calc(op, a, b);
      e.hi  = m_hi;
      e.lo  = m_lo;
      e.cyc = (op <= OP_MULTU) ? N_MUL : N_DIV;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    md_op = OP_NONE;
    req   = 1'b0;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] val);
    start = 1'b0;
    md_op = op;
    A     = val;
    if (op == OP_MTHI) m_hi = val;
    else m_lo = val;
    @(negedge clk);
    md_op = OP_NONE;
    chk("mt_hi", HI, m_hi);
    chk("mt_lo", LO, m_lo);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL wait_idle busy stuck actual=1 expected=0 at %0t", $time);
  endtask

  task automatic read_back(input string tag);
    md_op = OP_MFHI;
    #1 chk({tag, "_mfhi"}, md_out, m_hi);
    md_op = OP_MFLO;
    #1 chk({tag, "_mflo"}, md_out, m_lo);
    md_op = OP_NONE;
  endtask

  // Monitor: a busy falling edge is a commit; pop and compare.
  initial begin : monitor
    int   run;
    logic prev;
    exp_t e;
    run  = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        run  = 0;
        prev = 1'b0;
      end else begin
        if (busy) run++;
        if (prev && !busy) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL commit_unexpected actual=commit expected=none at %0t", $time);
          end else begin
            e = sb_q.pop_front();
            chk("commit_hi", HI, e.hi);
            chk("commit_lo", LO, e.lo);
            chk("busy_cycles", run, e.cyc);
          end
          run = 0;
        end
        prev = busy;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] a;
    logic [31:0] b;
    int          sel;

    reset = 1'b0;
    start = 1'b0;
    md_op = OP_NONE;
    A     = 32'd0;
    B     = 32'd0;
    req   = 1'b0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_md_out", md_out, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Signed vs unsigned multiply
    issue(OP_MULT, 32'hFFFFFFFF, 32'd2, 1'b0);
    wait_idle();
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFFE);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0);
    wait_idle();
    chk("multu_hi", HI, 32'h00000001);
    chk("multu_lo", LO, 32'hFFFFFFFE);

    // Signed vs unsigned divide
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_idle();
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);
    issue(OP_DIVU, 32'd7, 32'd2, 1'b0);
    wait_idle();
    chk("divu_lo", LO, 32'd3);
    chk("divu_hi", HI, 32'd1);

    // Divide by zero keeps HI/LO
    mt(OP_MTHI, 32'h1234);
    mt(OP_MTLO, 32'h5678);
    issue(OP_DIV, 32'd5, 32'd0, 1'b0);
    wait_idle();
    chk("dz_hi", HI, 32'h1234);
    chk("dz_lo", LO, 32'h5678);

    // req suppresses start and move-to
    issue(OP_MULT, 32'd3, 32'd4, 1'b1);
    chk("req_busy", {31'd0, busy}, 32'd0);
    md_op = OP_MTHI;
    A     = 32'hDEAD;
    req   = 1'b1;
    @(negedge clk);
    md_op = OP_NONE;
    req   = 1'b0;
    repeat (6) @(negedge clk);
    chk("req_busy_later", {31'd0, busy}, 32'd0);
    chk("req_hi", HI, 32'h1234);
    chk("req_lo", LO, 32'h5678);

    // req arriving mid-operation does not abort
    issue(OP_MULT, 32'd6, 32'd7, 1'b0);
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    wait_idle();
    chk("req_mid_lo", LO, 32'd42);
    chk("req_mid_hi", HI, 32'd0);

    // Move-to and a second start while busy are ignored
    issue(OP_MULTU, 32'h10, 32'h10, 1'b0);
    md_op = OP_MTLO;
    A     = 32'hAAAA;
    @(negedge clk);
    start = 1'b1;
    md_op = OP_DIVU;
    A     = 32'd99;
    B     = 32'd1;
    @(negedge clk);
    start = 1'b0;
    md_op = OP_NONE;
    wait_idle();
    chk("busy_mtlo_lo", LO, 32'h100);

    // MFLO across the commit edge, then back-to-back start at t+N+1
    issue(OP_MULT, 32'd3, 32'd5, 1'b0);
    md_op = OP_MFLO;
    repeat (N_MUL - 1) @(negedge clk);
    chk("mflo_before_commit", md_out, 32'h100);
    @(negedge clk);
    chk("mflo_after_commit", md_out, 32'd15);
    chk("b2b_idle", {31'd0, busy}, 32'd0);
    issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
    chk("b2b_accepted", {31'd0, busy}, 32'd1);
    wait_idle();

    // Reset in the middle of a divide
    issue(OP_DIV, 32'd1000, 32'd3, 1'b0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    sb_q.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", HI, 32'd0);
    chk("midrst_lo", LO, 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("midrst_busy_later", {31'd0, busy}, 32'd0);
    chk("midrst_hi_later", HI, 32'd0);
    chk("midrst_lo_later", LO, 32'd0);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 3);
      a = (sel == 0) ? 32'h80000000 : (sel == 1) ? 32'hFFFFFFFF : $urandom;
      sel = $urandom_range(0, 7);
      b = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFFFFFF : (sel == 2) ? 32'd1 : $urandom;
      sel = $urandom_range(0, 6);
      case (sel)
        0: issue(OP_MULT, a, b, 1'b0);
        1: issue(OP_MULTU, a, b, 1'b0);
        2: issue(OP_DIV, a, b, 1'b0);
        3: issue(OP_DIVU, a, b, 1'b0);
        4: mt(OP_MTHI, a);
        5: mt(OP_MTLO, a);
        default: begin
          issue(4'($urandom_range(9, 15)), a, b, 1'b0);
          chk("bad_op_busy", {31'd0, busy}, 32'd0);
        end
      endcase
      wait_idle();
      read_back("rand");
    end

    repeat (2) @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
